dmem_bwe: RTL and testbench

//  Parametrised single-port synchronous data memory for the LSU.

---
 rtl/dmem_bwe_pkg.sv | 14 +
 rtl/dmem_bwe_if.sv | 27 ++
 rtl/dmem_bwe_ram.sv | 35 +++
 rtl/dmem_bwe.sv | 171 +++++++++++++++++
 tb/tb_dmem_bwe.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bwe_pkg.sv
// Shared constants and FSM state encoding for the byte-write-enable data memory.
package dmem_bwe_pkg;

    localparam int DATA_LEN  = 32;
    localparam int ADDR_LEN  = 32;
    localparam int DMEM_SIZE = 8192;

    // Fill-then-serve controller states
    typedef enum logic {
        DMB_CLEAR = 1'b0,
        DMB_RUN   = 1'b1
    } dmb_state_e;

endpackage

// File: rtl/dmem_bwe_if.sv
// Request/response bus between the load/store unit (master) and dmem_bwe (slave).
interface dmem_bwe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_W/8-1:0]   req_be;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  init_done;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, init_done
    );

endinterface

// File: rtl/dmem_bwe_ram.sv
// Read-first single-port storage with byte lane write enables. The array has
// no reset so that synthesis can map it onto block RAM.
module dmem_bwe_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [IDX_W-1:0]    idx,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Capture the old word and merge the enabled byte lanes of the new one
    always_ff @(posedge clk) begin
        rdata_r <= mem_r[idx];
        if (we) begin
            for (int k = 0; k < BE_W; k++) begin
                if (be[k]) begin
                    mem_r[idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_bwe.sv
// Data memory for the LSU: zero-fill after reset, then one request per cycle
// with byte enables. Every accepted request (read or write) returns the word
// stored before the access, after 1 or 2 cycles depending on OUT_REG.
module dmem_bwe
    import dmem_bwe_pkg::*;
#(
    parameter int DATA_W         = DATA_LEN,
    parameter int DEPTH          = 2048,
    parameter int ADDR_W         = ADDR_LEN,
    parameter int CLEAR_ON_RESET = 1,
    parameter int OUT_REG        = 0
) (
    input  logic      clk,
    input  logic      reset_x,
    dmem_bwe_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;
    localparam dmb_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? DMB_CLEAR : DMB_RUN;

    dmb_state_e        state_r;
    dmb_state_e        state_s;
    logic [IDX_W-1:0]  clr_cnt_r;
    logic              req_ready_r;
    logic              init_done_r;
    logic              fire_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic              addr_unused_s;

    logic [IDX_W-1:0]  ram_idx_s;
    logic              ram_we_s;
    logic [BE_W-1:0]   ram_be_s;
    logic [DATA_W-1:0] ram_wdata_s;
    logic [DATA_W-1:0] ram_rdata_s;

    logic              pend_r;
    logic              mature_valid_s;
    logic [DATA_W-1:0] mature_data_s;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    // Word index from the byte address; the remaining bits alias freely
    assign req_idx_s     = bus.req_addr[IDX_W+1:2];
    assign addr_unused_s = ^{bus.req_addr[ADDR_W-1:IDX_W+2], bus.req_addr[1:0]};
    assign fire_s        = bus.req_valid & req_ready_r;

    // State register and fill counter
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_r   <= RESET_STATE;
            clr_cnt_r <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == DMB_CLEAR) begin
                clr_cnt_r <= clr_cnt_r + IDX_W'(1);
            end
        end
    end

    // Next state: leave CLEAR on the cycle that writes the last word
    always_comb begin
        state_s = state_r;
        case (state_r)
            DMB_CLEAR: begin
                if (clr_cnt_r == IDX_W'(DEPTH - 1)) begin
                    state_s = DMB_RUN;
                end else begin
                    state_s = DMB_CLEAR;
                end
            end
            DMB_RUN: state_s = DMB_RUN;
            default: state_s = RESET_STATE;
        endcase
    end

    // Ready and init flags follow the state being entered, so both rise on the first RUN cycle
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            req_ready_r <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            req_ready_r <= (state_s == DMB_RUN);
            init_done_r <= (state_s == DMB_RUN);
        end
    end

    // Storage port is owned by the fill engine during CLEAR, by the LSU afterwards
    always_comb begin
        ram_idx_s   = req_idx_s;
        ram_we_s    = 1'b0;
        ram_be_s    = bus.req_be;
        ram_wdata_s = bus.req_wdata;
        if (state_r == DMB_CLEAR) begin
            ram_idx_s   = clr_cnt_r;
            ram_we_s    = 1'b1;
            ram_be_s    = {BE_W{1'b1}};
            ram_wdata_s = {DATA_W{1'b0}};
        end else begin
            ram_idx_s   = req_idx_s;
            ram_we_s    = fire_s & bus.req_we;
            ram_be_s    = bus.req_be;
            ram_wdata_s = bus.req_wdata;
        end
    end

    dmem_bwe_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .idx   (ram_idx_s),
        .we    (ram_we_s),
        .be    (ram_be_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // First valid stage: marks that the RAM output register holds a response word
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= fire_s;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              pend2_r;
            logic [DATA_W-1:0] data2_r;

            // Extra pipeline stage for timing closure after the RAM
            always_ff @(posedge clk or negedge reset_x) begin
                if (!reset_x) begin
                    pend2_r <= 1'b0;
                    data2_r <= {DATA_W{1'b0}};
                end else begin
                    pend2_r <= pend_r;
                    data2_r <= ram_rdata_s;
                end
            end

            assign mature_valid_s = pend2_r;
            assign mature_data_s  = data2_r;
        end else begin : g_no_out_reg
            assign mature_valid_s = pend_r;
            assign mature_data_s  = ram_rdata_s;
        end
    endgenerate

    // Response register: data holds its last value between responses
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            rsp_valid_r <= mature_valid_s;
            if (mature_valid_s) begin
                rsp_rdata_r <= mature_data_s;
            end
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.init_done = init_done_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_bwe.sv
// Scoreboard bench for dmem_bwe: one instance per output-latency setting plus
// one without the zero-fill, all fed from the same request stream.
module tb_dmem_bwe;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_x = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] model [DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];

    dmem_bwe_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    dmem_bwe_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
    dmem_bwe_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

    assign if0.req_valid = req_valid;
    assign if0.req_we    = req_we;
    assign if0.req_be    = req_be;
    assign if0.req_addr  = req_addr;
    assign if0.req_wdata = req_wdata;
    assign if1.req_valid = req_valid;
    assign if1.req_we    = req_we;
    assign if1.req_be    = req_be;
    assign if1.req_addr  = req_addr;
    assign if1.req_wdata = req_wdata;
    assign if2.req_valid = req_valid;
    assign if2.req_we    = req_we;
    assign if2.req_be    = req_be;
    assign if2.req_addr  = req_addr;
    assign if2.req_wdata = req_wdata;

    dmem_bwe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_ON_RESET(1), .OUT_REG(0))
        dut0 (.clk(clk), .reset_x(reset_x), .bus(if0.slave));
    dmem_bwe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_ON_RESET(1), .OUT_REG(1))
        dut1 (.clk(clk), .reset_x(reset_x), .bus(if1.slave));
    dmem_bwe #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .CLEAR_ON_RESET(0), .OUT_REG(0))
        dut2 (.clk(clk), .reset_x(reset_x), .bus(if2.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard for the single-stage instance
    always @(negedge clk) begin : mon0
        logic ev;
        ev = (q0.size() > 0) && (q0[0].due == cyc);
        if (mon_en) begin
            check_eq("rsp0_valid", 32'(if0.rsp_valid), 32'(ev));
            if (ev) begin
                check_eq("rsp0_data", if0.rsp_rdata, q0[0].data);
                void'(q0.pop_front());
            end else if ((q0.size() > 0) && (q0[0].due < cyc)) begin
                void'(q0.pop_front());
            end
        end
    end

    // Scoreboard for the output-registered instance
    always @(negedge clk) begin : mon1
        logic ev;
        ev = (q1.size() > 0) && (q1[0].due == cyc);
        if (mon_en) begin
            check_eq("rsp1_valid", 32'(if1.rsp_valid), 32'(ev));
            if (ev) begin
                check_eq("rsp1_data", if1.rsp_rdata, q1[0].data);
                void'(q1.pop_front());
            end else if ((q1.size() > 0) && (q1[0].due < cyc)) begin
                void'(q1.pop_front());
            end
        end
    end

    // Drive one request for one cycle; expected old word goes to both scoreboards
    task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd);
        int   idx;
        exp_t e;
        @(negedge clk);
        check_eq("ready0", 32'(if0.req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        idx       = int'(addr[5:2]);
        e.data    = model[idx];
        e.due     = cyc + 2;
        q0.push_back(e);
        e.due     = cyc + 3;
        q1.push_back(e);
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) model[idx][8*k +: 8] = wd[8*k +: 8];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Release reset and time the fill; requests are offered throughout and must be ignored
    task automatic release_and_fill(input string tag);
        int n;
        @(negedge clk);
        reset_x   = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 4'hF;
        req_addr  = 32'h0000_0044;
        req_wdata = 32'hFFFF_FFFF;
        n = 0;
        while ((if0.init_done !== 1'b1) && (n < 100)) begin
            @(negedge clk);
            n++;
            if (n == 1) check_eq("noclear_init", 32'(if2.init_done), 32'd1);
            if (if0.init_done !== 1'b1) check_eq("clear_ready0", 32'(if0.req_ready), 32'd0);
        end
        req_valid = 1'b0;
        check_eq(tag, n, DEPTH);
        check_eq("fill_init1", 32'(if1.init_done), 32'd1);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        #2;
        reset_x = 1'b0;
        #1;
        mon_en = 1'b1;
        check_eq("rst_ready", 32'(if0.req_ready), 32'd0);
        check_eq("rst_init", 32'(if0.init_done), 32'd0);
        check_eq("rst_valid", 32'(if1.rsp_valid), 32'd0);
        check_eq("rst_rdata", if0.rsp_rdata, 32'h0);
        idle(2);

        // Fill timing, then every word reads back zero
        release_and_fill("fill_cycles");
        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 4'h0, 32'(i * 4), 32'h0);
        idle(4);

        // Byte-lane merge and read-first write responses
        do_req(1'b1, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF);
        do_req(1'b1, 4'b0010, 32'h0000_0040, 32'h0000_AA00);
        do_req(1'b0, 4'b0000, 32'h0000_0040, 32'h0);
        idle(1);
        do_req(1'b1, 4'b0000, 32'h0000_0040, 32'h1234_5678);
        do_req(1'b0, 4'b0000, 32'h0000_0040, 32'h0);
        idle(4);

        // Back-to-back write then read, and address aliasing
        do_req(1'b1, 4'b1111, 32'h0000_0024, 32'hCAFE_F00D);
        do_req(1'b0, 4'b0000, 32'h0000_0024, 32'h0);
        do_req(1'b1, 4'b1001, 32'h0000_0080, 32'hA1B2_C3D4);
        do_req(1'b0, 4'b0000, 32'h0000_0041, 32'h0);
        do_req(1'b0, 4'b0000, 32'hFFFF_FFC3, 32'h0);
        idle(4);

        // Random traffic with occasional gaps
        for (int i = 0; i < 60; i++) begin
            do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(4);

        // Reset in the middle of a read stream
        for (int i = 0; i < 4; i++) do_req(1'b0, 4'h0, 32'(i * 4), 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        check_eq("pre_rst_valid", 32'(if1.rsp_valid), 32'd1);
        reset_x = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check_eq("rst_drop0", 32'(if0.rsp_valid), 32'd0);
        check_eq("rst_drop1", 32'(if1.rsp_valid), 32'd0);
        idle(2);

        // Reset again part-way through the fill
        @(negedge clk);
        reset_x = 1'b1;
        idle(5);
        #2;
        reset_x = 1'b0;
        #1;
        check_eq("midfill_init", 32'(if0.init_done), 32'd0);
        idle(1);
        release_and_fill("refill_cycles");
        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 4'h0, 32'(i * 4), 32'h0);
        idle(5);
        check_eq("sb_empty0", 32'(q0.size()), 32'd0);
        check_eq("sb_empty1", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
